// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states,
// lane-select constants and the request legality check.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } lsu_state_t;

    // Byte lane n starts at bit n << LANE_SHIFT (little-endian)
    localparam int          LANE_SHIFT = 3;
    localparam int          BYTE_BITS  = 8;
    localparam int          HALF_BITS  = 16;
    localparam logic [31:0] BYTE_MASK  = 32'h0000_00FF;
    localparam logic [31:0] HALF_MASK  = 32'h0000_FFFF;

    // A request is rejected when its size code is illegal or its address is not naturally aligned
    function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: pulls a byte/half/word out of a memory word
// for loads, and merges store data into its lane for read-modify-write.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rd_word,
    input  logic [1:0]            addr_lo,
    input  logic [1:0]            size,
    input  logic                  is_unsigned,
    input  logic [DATA_WIDTH-1:0] st_data,
    output logic [DATA_WIDTH-1:0] ld_data,
    output logic [DATA_WIDTH-1:0] merged_word
);

    logic [4:0]            lane_shift;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] lane_mask;

    assign lane_shift = 5'(addr_lo) << LANE_SHIFT;
    assign shifted    = rd_word >> lane_shift;
    assign lane_mask  = (size == SZ_H) ? DATA_WIDTH'(HALF_MASK) : DATA_WIDTH'(BYTE_MASK);

    // Load path: move the addressed lane down to bit 0 and extend it
    always_comb begin
        ld_data = rd_word;
        case (size)
            SZ_B: ld_data = is_unsigned
                          ? {{(DATA_WIDTH-BYTE_BITS){1'b0}}, shifted[BYTE_BITS-1:0]}
                          : {{(DATA_WIDTH-BYTE_BITS){shifted[BYTE_BITS-1]}}, shifted[BYTE_BITS-1:0]};
            SZ_H: ld_data = is_unsigned
                          ? {{(DATA_WIDTH-HALF_BITS){1'b0}}, shifted[HALF_BITS-1:0]}
                          : {{(DATA_WIDTH-HALF_BITS){shifted[HALF_BITS-1]}}, shifted[HALF_BITS-1:0]};
            default: ld_data = rd_word;
        endcase
    end

    // Store path: a word store replaces everything, sub-word stores patch one lane of the old word
    always_comb begin
        merged_word = st_data;
        if (size != SZ_W) begin
            merged_word = (rd_word & ~(lane_mask << lane_shift))
                        | ((st_data & lane_mask) << lane_shift);
        end
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one CPU access at a time, performs a read,
// write or read-modify-write on a single-cycle word memory, and returns
// a one-cycle response with extended load data or an error flag.
module lsu
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lsu_state_t            state, next_state;
    logic                  accept;
    logic                  req_bad;

    logic                  lat_we;
    logic [1:0]            lat_size;
    logic                  lat_unsigned;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  lat_err;

    logic [DATA_WIDTH-1:0] rbuf;
    logic [ADDR_WIDTH-1:0] mem_addr_hold;
    logic [DATA_WIDTH-1:0] mem_wdata_hold;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [DATA_WIDTH-1:0] ld_data;
    logic [DATA_WIDTH-1:0] merged_word;

    assign accept    = req_valid && req_ready;
    assign req_bad   = req_is_bad(req_size, req_addr[1:0]);
    assign word_addr = {lat_addr[ADDR_WIDTH-1:2], 2'b00};

    lsu_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .rd_word     (rbuf),
        .addr_lo     (lat_addr[1:0]),
        .size        (lat_size),
        .is_unsigned (lat_unsigned),
        .st_data     (lat_wdata),
        .ld_data     (ld_data),
        .merged_word (merged_word)
    );

    // State register; reset drops straight back to IDLE, abandoning any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state: bad requests respond at once, loads and sub-word stores read first, aligned word stores write directly
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_bad)                             next_state = RESP;
                    else if (!req_we || req_size != SZ_W)    next_state = RD;
                    else                                     next_state = WR;
                end
            end
            RD:      next_state = lat_we ? WR : RESP;
            WR:      next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Capture the request on acceptance so the CPU is free to change its inputs afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we       <= 1'b0;
            lat_size     <= SZ_B;
            lat_unsigned <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_err      <= 1'b0;
        end else if (accept) begin
            lat_we       <= req_we;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            lat_err      <= req_bad;
        end
    end

    // Memory-side registers: read buffer, plus the last address/data driven so the bus stays stable when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbuf           <= '0;
            mem_addr_hold  <= '0;
            mem_wdata_hold <= '0;
        end else begin
            if (state == RD)                 rbuf           <= mem_rdata;
            if (state == RD || state == WR)  mem_addr_hold  <= word_addr;
            if (state == WR)                 mem_wdata_hold <= merged_word;
        end
    end

    // Outputs decoded from the current state; response data is zero for stores and errors
    always_comb begin
        req_ready  = (state == IDLE) && rst_n;
        mem_we     = (state == WR);
        mem_addr   = (state == RD || state == WR) ? word_addr : mem_addr_hold;
        mem_wdata  = (state == WR) ? merged_word : mem_wdata_hold;
        resp_valid = (state == RESP);
        resp_err   = (state == RESP) && lat_err;
        resp_rdata = '0;
        if (state == RESP && !lat_err && !lat_we) resp_rdata = ld_data;
    end

endmodule
